rfetch_scoreboard: RTL and testbench

RFETCH_SCOREBOARD -- requirements
Module: rfetch_scoreboard

---
 rtl/rfetch_scoreboard_if.sv | 34 +++
 rtl/rfetch_scoreboard.sv | 83 ++++++++
 tb/tb_rfetch_scoreboard.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/rfetch_scoreboard_if.sv
// rtl/rfetch_scoreboard_if.sv - decode/writeback/drain signal bundle for the rfetch scoreboard
interface rfetch_scoreboard_if #(
    parameter int reg_els_p = 32
);
    localparam int idx_w_lp = $clog2(reg_els_p);

    logic                decode_rfetch_v;
    logic [idx_w_lp-1:0] decode_rfetch_rs1;
    logic [idx_w_lp-1:0] decode_rfetch_rs2;
    logic [idx_w_lp-1:0] decode_rfetch_rd;
    logic                decode_rfetch_rs1_used;
    logic                decode_rfetch_rs2_used;
    logic                decode_rfetch_rd_w_v;
    logic                writeback_rfetch_rd_w_v;
    logic [idx_w_lp-1:0] writeback_rfetch_rd;
    logic                drain_req_i;
    logic                drain_done_o;
    logic                rfetch_stall_o;
    logic                rfetch_execute_v_o;

    modport master (
        output decode_rfetch_v, decode_rfetch_rs1, decode_rfetch_rs2, decode_rfetch_rd,
               decode_rfetch_rs1_used, decode_rfetch_rs2_used, decode_rfetch_rd_w_v,
               writeback_rfetch_rd_w_v, writeback_rfetch_rd, drain_req_i,
        input  drain_done_o, rfetch_stall_o, rfetch_execute_v_o
    );

    modport slave (
        input  decode_rfetch_v, decode_rfetch_rs1, decode_rfetch_rs2, decode_rfetch_rd,
               decode_rfetch_rs1_used, decode_rfetch_rs2_used, decode_rfetch_rd_w_v,
               writeback_rfetch_rd_w_v, writeback_rfetch_rd, drain_req_i,
        output drain_done_o, rfetch_stall_o, rfetch_execute_v_o
    );
endinterface

// File: rtl/rfetch_scoreboard.sv
// rtl/rfetch_scoreboard.sv - register-fetch pending-write scoreboard with drain FSM
module rfetch_scoreboard #(
    parameter int reg_els_p  = 32,
    parameter int max_pend_p = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    rfetch_scoreboard_if.slave                 sb,
    output logic [$clog2(max_pend_p+1)-1:0]    pend_cnt_o,
    output logic [15:0]                        stall_cycles_o
);
    localparam int cnt_w_lp = $clog2(max_pend_p+1);
    localparam logic [cnt_w_lp-1:0] max_cnt_lp = cnt_w_lp'(max_pend_p);

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_e;

    state_e                state_r, state_n;
    logic [reg_els_p-1:0]  pend_r, pend_n;
    logic [cnt_w_lp-1:0]   cnt_n;
    logic                  hazard, full, issue, set_v, clr_v, exec_v_r;

    // Hazards look at pre-edge pending bits only; a retiring write is not bypassed.
    always_comb begin
        hazard = sb.decode_rfetch_v &&
                 ((sb.decode_rfetch_rs1_used && (sb.decode_rfetch_rs1 != '0) && pend_r[sb.decode_rfetch_rs1]) ||
                  (sb.decode_rfetch_rs2_used && (sb.decode_rfetch_rs2 != '0) && pend_r[sb.decode_rfetch_rs2]) ||
                  (sb.decode_rfetch_rd_w_v   && (sb.decode_rfetch_rd  != '0) && pend_r[sb.decode_rfetch_rd]));
        full   = sb.decode_rfetch_v && sb.decode_rfetch_rd_w_v && (sb.decode_rfetch_rd != '0) &&
                 (pend_cnt_o == max_cnt_lp);
    end

    assign sb.rfetch_stall_o     = sb.decode_rfetch_v && (hazard || full || (state_r != RUN));
    assign issue                 = sb.decode_rfetch_v && !sb.rfetch_stall_o;
    assign set_v                 = issue && sb.decode_rfetch_rd_w_v && (sb.decode_rfetch_rd != '0);
    assign clr_v                 = sb.writeback_rfetch_rd_w_v && (sb.writeback_rfetch_rd != '0) &&
                                   pend_r[sb.writeback_rfetch_rd];
    assign sb.rfetch_execute_v_o = exec_v_r;

    // set and clear never hit the same register: a set needs rd not pending, a clear needs it pending
    always_comb begin
        pend_n = pend_r;
        cnt_n  = pend_cnt_o;
        if (clr_v) pend_n[sb.writeback_rfetch_rd] = 1'b0;
        if (set_v) pend_n[sb.decode_rfetch_rd]    = 1'b1;
        pend_n[0] = 1'b0;
        case ({set_v, clr_v})
            2'b10:   cnt_n = pend_cnt_o + cnt_w_lp'(1);
            2'b01:   cnt_n = pend_cnt_o - cnt_w_lp'(1);
            default: cnt_n = pend_cnt_o;
        endcase
    end

    always_comb begin
        state_n         = state_r;
        sb.drain_done_o = 1'b0;
        case (state_r)
            RUN:     if (sb.drain_req_i) state_n = DRAIN;
            DRAIN:   if (cnt_n == '0)    state_n = DONE;
            DONE: begin
                sb.drain_done_o = 1'b1;
                state_n         = RUN;
            end
            default: state_n = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r        <= RUN;
            pend_r         <= '0;
            pend_cnt_o     <= '0;
            exec_v_r       <= 1'b0;
            stall_cycles_o <= '0;
        end else begin
            state_r    <= state_n;
            pend_r     <= pend_n;
            pend_cnt_o <= cnt_n;
            exec_v_r   <= issue;
            if (sb.rfetch_stall_o && (stall_cycles_o != 16'hFFFF))
                stall_cycles_o <= stall_cycles_o + 16'd1;
        end
    end
endmodule

// File: tb/tb_rfetch_scoreboard.sv
// tb/tb_rfetch_scoreboard.sv - self-checking bench for rfetch_scoreboard
`timescale 1ns/1ps
module tb_rfetch_scoreboard;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  pend_cnt;
    logic [15:0] stall_cycles;

    rfetch_scoreboard_if #(.reg_els_p(32)) ifc ();

    rfetch_scoreboard #(.reg_els_p(32), .max_pend_p(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .sb             (ifc),
        .pend_cnt_o     (pend_cnt),
        .stall_cycles_o (stall_cycles)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    bit       m_pend [32];
    int       m_cnt, m_state, m_sc;
    bit       exp_q [$];
    bit       obs_stall;

    bit       s_v, s_u1, s_u2, s_rdw, s_wbv, s_drain;
    bit [4:0] s_rs1, s_rs2, s_rd, s_wbrd;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic instr(input bit v, input bit [4:0] rs1, input bit u1,
                         input bit [4:0] rs2, input bit u2, input bit [4:0] rd, input bit rdw);
        s_v = v; s_rs1 = rs1; s_u1 = u1; s_rs2 = rs2; s_u2 = u2; s_rd = rd; s_rdw = rdw;
    endtask

    task automatic wb(input bit v, input bit [4:0] rd);
        s_wbv = v; s_wbrd = rd;
    endtask

    task automatic model_reset();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_cnt = 0; m_state = 0; m_sc = 0;
        exp_q.delete();
    endtask

    task automatic tick();
        bit haz, full, stl, iss, set, clr, e;
        int ncnt, nst;
        @(negedge clk);
        ifc.decode_rfetch_v         = s_v;
        ifc.decode_rfetch_rs1       = s_rs1;
        ifc.decode_rfetch_rs1_used  = s_u1;
        ifc.decode_rfetch_rs2       = s_rs2;
        ifc.decode_rfetch_rs2_used  = s_u2;
        ifc.decode_rfetch_rd        = s_rd;
        ifc.decode_rfetch_rd_w_v    = s_rdw;
        ifc.writeback_rfetch_rd_w_v = s_wbv;
        ifc.writeback_rfetch_rd     = s_wbrd;
        ifc.drain_req_i             = s_drain;
        #1;
        haz  = s_v && ((s_u1 && s_rs1 != 0 && m_pend[s_rs1]) ||
                       (s_u2 && s_rs2 != 0 && m_pend[s_rs2]) ||
                       (s_rdw && s_rd != 0 && m_pend[s_rd]));
        full = s_v && s_rdw && s_rd != 0 && m_cnt == 4;
        stl  = s_v && (haz || full || m_state != 0);
        iss  = s_v && !stl;
        obs_stall = ifc.rfetch_stall_o;
        check_val("stall", obs_stall, stl);
        exp_q.push_back(iss);
        set  = iss && s_rdw && s_rd != 0;
        clr  = s_wbv && s_wbrd != 0 && m_pend[s_wbrd];
        ncnt = m_cnt + int'(set) - int'(clr);
        case (m_state)
            0:       nst = s_drain ? 1 : 0;
            1:       nst = (ncnt == 0) ? 2 : 1;
            default: nst = 0;
        endcase
        @(posedge clk);
        #1;
        if (clr) m_pend[s_wbrd] = 1'b0;
        if (set) m_pend[s_rd] = 1'b1;
        m_cnt   = ncnt;
        m_state = nst;
        if (stl && m_sc < 65535) m_sc++;
        if (exp_q.size() == 0) begin
            check_val("exec_v_queue_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            check_val("exec_v", ifc.rfetch_execute_v_o, e);
        end
        check_val("pend_cnt", pend_cnt, m_cnt);
        check_val("drain_done", ifc.drain_done_o, m_state == 2);
        check_val("stall_cycles", stall_cycles, m_sc);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        instr(0, 0, 0, 0, 0, 0, 0); wb(0, 0); s_drain = 0;
        ifc.decode_rfetch_v = 0; ifc.decode_rfetch_rs1 = 0; ifc.decode_rfetch_rs2 = 0;
        ifc.decode_rfetch_rd = 0; ifc.decode_rfetch_rs1_used = 0; ifc.decode_rfetch_rs2_used = 0;
        ifc.decode_rfetch_rd_w_v = 0; ifc.writeback_rfetch_rd_w_v = 0; ifc.writeback_rfetch_rd = 0;
        ifc.drain_req_i = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_val("rst_exec_v", ifc.rfetch_execute_v_o, 0);
        check_val("rst_pend_cnt", pend_cnt, 0);
        check_val("rst_drain_done", ifc.drain_done_o, 0);
        check_val("rst_stall_cycles", stall_cycles, 0);
        check_val("rst_stall", ifc.rfetch_stall_o, 0);
        rst = 1'b1;

        // RAW on x5
        instr(1, 0, 0, 0, 0, 5, 1); tick();
        check_val("raw_cnt", pend_cnt, 1);
        instr(1, 5, 1, 0, 0, 0, 0); tick();
        check_val("raw_stall_a", obs_stall, 1);
        tick();
        check_val("raw_stall_b", obs_stall, 1);
        wb(1, 5); tick();
        check_val("raw_no_bypass", obs_stall, 1);
        wb(0, 0); tick();
        check_val("raw_issue", obs_stall, 0);
        check_val("raw_exec_v", ifc.rfetch_execute_v_o, 1);

        // x0 never becomes pending
        instr(1, 0, 0, 0, 0, 0, 1); tick();
        check_val("x0_write_stall", obs_stall, 0);
        instr(1, 0, 1, 0, 0, 0, 0); tick();
        check_val("x0_read_stall", obs_stall, 0);
        check_val("x0_cnt", pend_cnt, 0);

        // full: four writers in flight
        for (int r = 1; r <= 4; r++) begin
            instr(1, 0, 0, 0, 0, 5'(r), 1); tick();
        end
        check_val("full_cnt4", pend_cnt, 4);
        instr(1, 0, 0, 0, 0, 6, 1); tick();
        check_val("full_stall", obs_stall, 1);
        wb(1, 2); tick();
        check_val("full_stall_wb_cycle", obs_stall, 1);
        wb(0, 0); tick();
        check_val("full_issue", obs_stall, 0);
        check_val("full_cnt_after", pend_cnt, 4);
        instr(0, 0, 0, 0, 0, 0, 0);
        foreach (exp_q[i]) ; // keep queue as is
        wb(1, 1); tick(); wb(1, 3); tick(); wb(1, 4); tick(); wb(1, 6); tick();
        wb(1, 6); tick();
        check_val("full_drained_cnt", pend_cnt, 0);
        wb(0, 0);

        // drain with two writers in flight
        instr(1, 0, 0, 0, 0, 7, 1); tick();
        instr(1, 0, 0, 0, 0, 8, 1); tick();
        check_val("drain_cnt2", pend_cnt, 2);
        instr(1, 9, 1, 0, 0, 0, 0); s_drain = 1; tick();
        check_val("drain_req_cycle_issue", obs_stall, 0);
        s_drain = 0; tick();
        check_val("drain_hold", obs_stall, 1);
        wb(1, 7); tick();
        check_val("drain_not_done", ifc.drain_done_o, 0);
        wb(1, 8); tick();
        check_val("drain_done_pulse", ifc.drain_done_o, 1);
        wb(0, 0); s_drain = 1; tick();
        check_val("done_stall", obs_stall, 1);
        check_val("done_single", ifc.drain_done_o, 0);
        s_drain = 0; tick();
        check_val("resume_issue", obs_stall, 0);

        // async reset in the middle of a drain
        for (int r = 10; r <= 12; r++) begin
            instr(1, 0, 0, 0, 0, 5'(r), 1); tick();
        end
        instr(0, 0, 0, 0, 0, 0, 0); s_drain = 1; tick();
        s_drain = 0; instr(1, 10, 1, 0, 0, 0, 0); tick();
        check_val("pre_rst_cnt", pend_cnt, 3);
        check_val("pre_rst_stall", obs_stall, 1);
        @(negedge clk); #2 rst = 1'b0; #1;
        check_val("arst_exec_v", ifc.rfetch_execute_v_o, 0);
        check_val("arst_cnt", pend_cnt, 0);
        check_val("arst_done", ifc.drain_done_o, 0);
        check_val("arst_stall_cycles", stall_cycles, 0);
        check_val("arst_stall", ifc.rfetch_stall_o, 0);
        model_reset();
        @(negedge clk); rst = 1'b1;
        tick();
        check_val("post_rst_issue", obs_stall, 0);
        instr(0, 0, 0, 0, 0, 0, 0); wb(1, 10); tick();
        check_val("post_rst_stale_wb", pend_cnt, 0);

        // randomised traffic on x0..x7
        for (int i = 0; i < 300; i++) begin
            instr($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom_range(0, 1),
                  5'($urandom_range(0, 7)), $urandom_range(0, 1),
                  5'($urandom_range(0, 7)), $urandom_range(0, 1));
            wb($urandom_range(0, 1), 5'($urandom_range(0, 7)));
            s_drain = ($urandom_range(0, 29) == 0);
            tick();
        end
        s_drain = 0; instr(0, 0, 0, 0, 0, 0, 0);
        for (int r = 1; r <= 7; r++) begin
            wb(1, 5'(r)); tick();
        end
        wb(0, 0); repeat (3) tick();
        check_val("rand_cleanup_cnt", pend_cnt, 0);

        // long stall to saturate the perf counter
        instr(1, 0, 0, 0, 0, 13, 1); tick();
        instr(1, 13, 1, 0, 0, 0, 0); tick();
        check_val("sat_stall_start", obs_stall, 1);
        repeat (70000) @(posedge clk);
        m_sc = (m_sc + 70000 > 65535) ? 65535 : m_sc + 70000;
        tick();
        check_val("stall_sat", stall_cycles, 16'hFFFF);
        wb(1, 13); tick();
        wb(0, 0); tick();
        check_val("sat_release_issue", obs_stall, 0);
        check_val("sat_hold", stall_cycles, 16'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
